// File: rtl/stepper_phase_driver.sv
// Stepper coil phase driver: consumes sign flags from a step-count register, steps
// the coils at a programmable rate and returns one decrement/increment pulse per step.
module stepper_phase_driver #(
    parameter int PERIOD_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                half_step,
    input  logic [PERIOD_W-1:0] step_period,
    input  logic                negative,
    input  logic                positive,
    input  logic                zero,
    output logic                decrement_n,
    output logic                increment_n,
    output logic [3:0]          phase,
    output logic                busy,
    output logic                done,
    output logic                fault
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          idx_reg, idx_next, idx_stepped;
    logic [PERIOD_W-1:0] timer_reg, timer_next;
    logic [PERIOD_W-1:0] period_reg, period_next, period_eff;
    logic [3:0]          phase_reg, phase_next;
    logic                dec_reg, dec_next;
    logic                inc_reg, inc_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                fault_reg, fault_next;
    logic                request, conflict, evaluate, take_step;

    function automatic logic [3:0] phase_of(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b1000;
            3'd1:    p = 4'b1100;
            3'd2:    p = 4'b0100;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0010;
            3'd5:    p = 4'b0011;
            3'd6:    p = 4'b0001;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            idx_reg    <= 3'd0;
            timer_reg  <= '0;
            period_reg <= PERIOD_W'(2);
            phase_reg  <= 4'b0000;
            dec_reg    <= 1'b1;
            inc_reg    <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            timer_reg  <= timer_next;
            period_reg <= period_next;
            phase_reg  <= phase_next;
            dec_reg    <= dec_next;
            inc_reg    <= inc_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            fault_reg  <= fault_next;
        end
    end

    // Flags are only looked at in IDLE or on the last clock of an interval, which
    // gives the step register time to absorb the previous pulse.
    always_comb begin
        period_eff = (step_period < PERIOD_W'(2)) ? PERIOD_W'(2) : step_period;
        request    = enable & ~zero & (positive ^ negative);
        conflict   = enable & ~zero & positive & negative;
        evaluate   = (state_reg == IDLE) || (timer_reg == period_reg - PERIOD_W'(1));
        take_step  = evaluate & request;

        if (half_step)
            idx_stepped = positive ? idx_reg + 3'd1 : idx_reg - 3'd1;
        else
            idx_stepped = (positive ? idx_reg + 3'd2 : idx_reg - 3'd2) | 3'd1;

        state_next  = state_reg;
        idx_next    = idx_reg;
        timer_next  = timer_reg;
        period_next = period_reg;
        if (!enable) begin
            state_next = IDLE;
            timer_next = '0;
        end else if (take_step) begin
            state_next  = WAIT;
            idx_next    = idx_stepped;
            timer_next  = '0;
            period_next = period_eff;
        end else if (state_reg == WAIT) begin
            if (evaluate) begin
                state_next = IDLE;
                timer_next = '0;
            end else begin
                timer_next = timer_reg + PERIOD_W'(1);
            end
        end
    end

    always_comb begin
        phase_next = enable ? phase_of(idx_next) : 4'b0000;
        dec_next   = ~(take_step & positive);
        inc_next   = ~(take_step & negative);
        done_next  = enable & (state_reg == WAIT) & evaluate & ~take_step & zero;
        busy_next  = (state_next == WAIT);
        fault_next = fault_reg | (evaluate & conflict);
    end

    assign phase       = phase_reg;
    assign decrement_n = dec_reg;
    assign increment_n = inc_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign fault       = fault_reg;

endmodule
